seq_divider: RTL
================

# seq_divider

Parametrised multi-cycle integer divider producing quotient and remainder with a request/ready handshake. It succeeds the fixed 16-bit unsigned divider and adds a width parameter, per-request signed/unsigned mode, divide-by-zero reporting, a busy indication, and a defined result for signed overflow. It sits beside the ALU as the long-latency divide unit of the CPU datapath. It uses a restoring radix-2 algorithm and retires one quotient bit per cycle.

## Interface
- N, 16, operand and result width in bits (N >= 2)
- clk  input  1  rising-edge clock
- rstn  input  1  asynchronous active-low reset
- req  input  1  start request; sampled only in IDLE
- signed_mode  input  1  1 = two's-complement operands and results, 0 = unsigned; sampled with req
- Dividend  input  N  dividend; sampled with req
- Divisor  input  N  divisor; sampled with req
- Q  output  N  quotient; registered, holds last result
- R  output  N  remainder; registered, holds last result
- ready  output  1  one-cycle pulse: Q, R and div_by_zero are valid for the completed request
- busy  output  1  high in every state except IDLE
- div_by_zero  output  1  registered; set with ready when Divisor was 0, cleared at next accepted req

## Operation
- Reset (rstn low, asynchronous) forces the FSM to IDLE and sets Q=0, R=0, ready=0, busy=0, div_by_zero=0. An in-flight division is discarded with no ready pulse.
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE: when req=1, capture Dividend, Divisor and signed_mode, clear div_by_zero, and go to PREP. When req=0, stay in IDLE.
- PREP: when Divisor==0, load Q=all ones and R=captured Dividend, set div_by_zero, and go to DONE. Otherwise form magnitudes, using two's-complement absolute values only when signed_mode=1 and the operand MSB is 1. Record sign_q = sD XOR sd and sign_r = sD, clear the N-bit iteration counter, and go to ITER.
- ITER: each cycle shift {partial remainder, magnitude dividend} left by 1 and trial-subtract the divisor magnitude using an N+1-bit subtractor. A non-negative result commits the subtraction and shifts in quotient bit 1; otherwise it shifts in 0. After exactly N iterations go to FIX.
- FIX: negate the quotient when sign_q=1 and the remainder when sign_r=1 (signed mode only). Load Q and R and go to DONE.
- DONE: ready=1 for this cycle only; next state is IDLE.
- Quotient truncates toward zero. The remainder takes the sign of the dividend.
- Signed overflow (most-negative / -1): the algorithm yields Q = most-negative, R = 0, with no flag. The magnitude path is N bits unsigned, so 2^(N-1) is representable.
- A req arriving while busy=1 is ignored and not queued. Changes to operand inputs while busy do not affect the in-flight result.

## Timing
- Req accepted at clock edge k leads to PREP at k, ITER from k+1 to k+N, FIX at k+N+1, and DONE at k+N+2. ready is high in the cycle after edge k+N+2, giving a latency of N+3 edges.
- Divide-by-zero: PREP at k, DONE at k+1, ready in the cycle after edge k+1.
- Q, R and div_by_zero update on the same edge that raises ready and hold until the next result or reset.
- busy rises on the accepting edge and falls on the edge after ready (the return to IDLE).
- When req is held continuously high, the next acceptance occurs at the first edge in IDLE: one request per N+4 edges, or 3 for divide-by-zero.

## Test plan
- Unsigned 65000/6700, N=16 -> Q=9, R=4700, div_by_zero=0; ready exactly 19 edges after acceptance.
- Signed -7/2 (0xFFF9/0x0002) -> Q=0xFFFD (-3), R=0xFFFF (-1). Signed 7/-2 -> Q=0xFFFD, R=0x0001.
- 1234/0 in either mode -> Q=0xFFFF, R=1234, div_by_zero=1, ready 2 edges after acceptance. A following 10/3 clears the flag and gives Q=3, R=1.
- Signed 0x8000/0xFFFF -> Q=0x8000, R=0. The same operands unsigned -> Q=0, R=0x8000.
- Assert rstn low mid-ITER, then start 100/7 -> all outputs are 0 during reset, there is no stale ready, and the new result is Q=14, R=2.
- Hold req high while changing operands during busy -> only the operands sampled in IDLE are used, one ready per N+4 edges, and busy/ready never overlap an accept.

Source files
------------

// File: rtl/seq_divider.sv
//------------------------------------------------------------------------------
// seq_divider
//   Multi-cycle restoring radix-2 integer divider, one quotient bit per cycle.
//   Handles signed (two's-complement) or unsigned operands per request,
//   reports divide-by-zero, and gives a defined result on signed overflow
//   (most-negative / -1 -> Q = most-negative, R = 0).
//
// Ports
//   clk          rising-edge clock
//   rstn         asynchronous active-low reset
//   req          start request, sampled only in IDLE
//   signed_mode  1 = signed operands/results, sampled with req
//   Dividend     N-bit dividend, sampled with req
//   Divisor      N-bit divisor, sampled with req
//   Q, R         registered quotient / remainder, hold the last result
//   ready        one-cycle pulse when Q, R, div_by_zero are valid
//   busy         high in every state except IDLE
//   div_by_zero  set with ready when the divisor was 0, cleared on next accept
//------------------------------------------------------------------------------
module seq_divider #(
    parameter int unsigned N = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         req,
    input  logic         signed_mode,
    input  logic [N-1:0] Dividend,
    input  logic [N-1:0] Divisor,
    output logic [N-1:0] Q,
    output logic [N-1:0] R,
    output logic         ready,
    output logic         busy,
    output logic         div_by_zero
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    localparam int unsigned   LAST_I = N - 1;
    localparam logic [N-1:0]  LAST   = LAST_I[N-1:0];

    state_t       state_q, state_d;

    // Captured request
    logic [N-1:0] a_q, a_d;
    logic [N-1:0] b_q, b_d;
    logic         sm_q, sm_d;

    // Iteration datapath: quo_q starts as the dividend magnitude and
    // fills with quotient bits from the right as it shifts out.
    logic [N-1:0] rem_q, rem_d;
    logic [N-1:0] quo_q, quo_d;
    logic [N-1:0] mdsr_q, mdsr_d;
    logic         sgn_q_q, sgn_q_d;
    logic         sgn_r_q, sgn_r_d;
    logic [N-1:0] cnt_q, cnt_d;

    // Result registers
    logic [N-1:0] q_q, q_d;
    logic [N-1:0] r_q, r_d;
    logic         dbz_q, dbz_d;

    // Combinational helpers
    logic         neg_a, neg_b;
    logic [N-1:0] mag_a, mag_b;
    logic [N:0]   shifted;
    logic [N:0]   diff;
    logic         trial_ok;

    always_comb begin
        neg_a   = sm_q & a_q[N-1];
        neg_b   = sm_q & b_q[N-1];
        mag_a   = neg_a ? ('0 - a_q) : a_q;
        mag_b   = neg_b ? ('0 - b_q) : b_q;
        shifted = {rem_q, quo_q[N-1]};
        diff    = shifted - {1'b0, mdsr_q};
        // The partial remainder is always below the divisor, so shifted is
        // below twice the divisor; bit N of the N+1-bit difference is then
        // a reliable borrow/sign indicator.
        trial_ok = ~diff[N];
    end

    //--------------------------------------------------------------------------
    // FSM: state register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    //--------------------------------------------------------------------------
    // FSM: next state
    //--------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req) state_d = S_PREP;
            S_PREP:  state_d = (b_q == '0) ? S_DONE : S_ITER;
            S_ITER:  if (cnt_q == LAST) state_d = S_FIX;
            S_FIX:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    //--------------------------------------------------------------------------
    // FSM: outputs
    //--------------------------------------------------------------------------
    always_comb begin
        ready = (state_q == S_DONE);
        busy  = (state_q != S_IDLE);
    end

    assign Q           = q_q;
    assign R           = r_q;
    assign div_by_zero = dbz_q;

    //--------------------------------------------------------------------------
    // Datapath next-state
    //--------------------------------------------------------------------------
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sm_d    = sm_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        mdsr_d  = mdsr_q;
        sgn_q_d = sgn_q_q;
        sgn_r_d = sgn_r_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        dbz_d   = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    a_d   = Dividend;
                    b_d   = Divisor;
                    sm_d  = signed_mode;
                    dbz_d = 1'b0;
                end
            end
            S_PREP: begin
                if (b_q == '0) begin
                    q_d   = '1;
                    r_d   = a_q;
                    dbz_d = 1'b1;
                end else begin
                    quo_d   = mag_a;
                    mdsr_d  = mag_b;
                    rem_d   = '0;
                    sgn_q_d = neg_a ^ neg_b;
                    sgn_r_d = neg_a;
                    cnt_d   = '0;
                end
            end
            S_ITER: begin
                rem_d = trial_ok ? diff[N-1:0] : shifted[N-1:0];
                quo_d = {quo_q[N-2:0], trial_ok};
                cnt_d = cnt_q + 1'b1;
            end
            S_FIX: begin
                q_d = sgn_q_q ? ('0 - quo_q) : quo_q;
                r_d = sgn_r_q ? ('0 - rem_q) : rem_q;
            end
            default: ;
        endcase
    end

    //--------------------------------------------------------------------------
    // Datapath registers
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_q     <= '0;
            b_q     <= '0;
            sm_q    <= 1'b0;
            rem_q   <= '0;
            quo_q   <= '0;
            mdsr_q  <= '0;
            sgn_q_q <= 1'b0;
            sgn_r_q <= 1'b0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sm_q    <= sm_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            mdsr_q  <= mdsr_d;
            sgn_q_q <= sgn_q_d;
            sgn_r_q <= sgn_r_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
        end
    end

endmodule
